fighter_action_fsm: RTL and testbench
=====================================

Name: fighter_action_fsm

Overview:
- Game-side consumer of the per-player controller signals: left, right, up, down, attack, pery.
- Turns held and pressed controls into a frame-timed fighter state, horizontal position, jump height offset and attack/parry windows.
- Sits between the player controller and the renderer/collision logic; one instance per player.
- All gameplay timing advances only on a frame strobe (tick), not on raw clk.

Parameters:
- X_MIN, 0: leftmost legal pos_x.
- X_MAX, 575: rightmost legal pos_x.
- X_INIT, 64: pos_x after reset.
- WALK_STEP, 2: pixels moved per tick while walking or airborne.
- JUMP_FRAMES, 32: total airborne ticks; must be even.
- JUMP_STEP, 4: y_off change per tick.
- ATK_ACTIVE_FRAMES, 6: ticks with attack_active high.
- ATK_RECOVER_FRAMES, 10: lockout ticks after the active window.
- PARRY_FRAMES, 8: ticks with parry_active high.
- HITSTUN_FRAMES, 20: stun ticks after being hit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk frame strobe (~60 Hz).
- left, right, up, down  in  1 each  active-high, debounced, synchronous to clk.
- attack, pery  in  1 each  active-high, debounced, synchronous to clk.
- hit_in  in  1  one-clk pulse: opponent attack connected.
- state  out  3  current state code.
- pos_x  out  10  horizontal position.
- y_off  out  8  height above ground.
- attack_active  out  1  attack hitbox live.
- parry_active  out  1  parry window open.
- parry_success  out  1  one-clk pulse.

Behaviour:
- Reset values: state=IDLE, pos_x=X_INIT, y_off=0, all flags 0, frame counter 0, button history 0.
- Timing: every output is a register; updates happen on the clk edge where tick=1, so latency is one clk after tick.
- hit_in exception: hit_in is evaluated every clk (see Hit handling), not only on tick.
- Press detection: attack_press = attack & ~attack_prev, sampled on tick; same for pery. Prev registers update only on tick. Holding a button never retriggers.
- States and codes: IDLE=0, WALK=1, JUMP=2, CROUCH=3, ATTACK=4, RECOVER=5, PARRY=6, HITSTUN=7.
- IDLE/WALK/CROUCH, on tick, priority order:
  - pery press → PARRY, counter=PARRY_FRAMES.
  - attack press → ATTACK, counter=ATK_ACTIVE_FRAMES.
  - up → JUMP, counter=JUMP_FRAMES.
  - down → CROUCH.
  - exactly one of left/right → WALK.
  - otherwise → IDLE.
  - left and right together count as no horizontal input.
- Movement: in WALK and JUMP, pos_x ±= WALK_STEP, saturating at X_MIN/X_MAX with no wrap. CROUCH does not move.
- JUMP:
  - First JUMP_FRAMES/2 ticks: y_off += JUMP_STEP. Remaining ticks: y_off -= JUMP_STEP.
  - When the counter reaches 0: y_off is exactly 0, go to IDLE.
  - up held on landing starts a new jump on the next tick.
- ATTACK: attack_active=1 throughout. Counter expiry → RECOVER, counter=ATK_RECOVER_FRAMES. RECOVER expiry → IDLE. All inputs are ignored in both states.
- PARRY: parry_active=1. Counter expiry → IDLE.
- Hit handling (any clk):
  - In PARRY: parry_success pulses for one clk; state and counter are unchanged.
  - In any other state, including HITSTUN: go to HITSTUN, counter=HITSTUN_FRAMES (a hit in HITSTUN reloads the counter), y_off=0, attack_active=0.
- HITSTUN expiry → IDLE.
- Simultaneous hit_in and tick on the same clk: the hit wins and the tick is consumed.
- Counter decrements once per tick; the transition happens on the tick where the counter goes 1→0.
- reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- FIGHTER_AIR_ATTACK_EN defined: an attack press in JUMP sets attack_active for ATK_ACTIVE_FRAMES ticks using a second counter. The jump arc and movement continue; there is no RECOVER. A second press during the window is ignored. Landing clears attack_active.
- Undefined: attack presses in JUMP are ignored, and the edge is still consumed.

Decomposition:
- Shared package fighter_pkg:
  - State code localparams.
  - Frame-count defaults.
  - Position limits.
- Sub-module frame_counter:
  - Loadable down-counter with load, value, tick, and zero output.
  - One instance for the main state; a second instance under FIGHTER_AIR_ATTACK_EN.

Test Plan:
- Reset, then hold right for 10 ticks → pos_x=84, state=WALK. Release → IDLE on the next tick.
- pos_x=574, hold right 3 ticks → pos_x=575 saturated, no wrap. Left+right held → state IDLE, pos_x unchanged.
- up pulse → y_off peaks at 64 after 16 ticks, returns to 0 at tick 32, then IDLE. Right held during jump → pos_x +64.
- Hold attack for 30 ticks → attack_active exactly 6 ticks, then RECOVER 10 ticks, then IDLE, and no second attack.
- pery press, then hit_in at parry tick 3 → parry_success one clk, state stays 6, IDLE after 8 ticks.
- Mid-jump hit_in coinciding with tick → HITSTUN, y_off=0. Second hit_in at stun tick 15 → HITSTUN lasts 20 more ticks. Under FIGHTER_AIR_ATTACK_EN, attack at jump tick 5 → attack_active 6 ticks while y_off keeps rising.

Source files
------------

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - fighter state codes, frame-count defaults, position limits and x stepping helper
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK    = 3'd1,
        ST_JUMP    = 3'd2,
        ST_CROUCH  = 3'd3,
        ST_ATTACK  = 3'd4,
        ST_RECOVER = 3'd5,
        ST_PARRY   = 3'd6,
        ST_HITSTUN = 3'd7
    } fighter_state_e;

    localparam int DEF_X_MIN              = 0;
    localparam int DEF_X_MAX              = 575;
    localparam int DEF_X_INIT             = 64;
    localparam int DEF_WALK_STEP          = 2;
    localparam int DEF_JUMP_FRAMES        = 32;
    localparam int DEF_JUMP_STEP          = 4;
    localparam int DEF_ATK_ACTIVE_FRAMES  = 6;
    localparam int DEF_ATK_RECOVER_FRAMES = 10;
    localparam int DEF_PARRY_FRAMES       = 8;
    localparam int DEF_HITSTUN_FRAMES     = 20;

    localparam int CNT_W = 8;

    // Saturating horizontal step; left and right together means no motion.
    function automatic logic [9:0] step_x(input logic [9:0] pos, input logic go_left,
                                          input logic go_right, input int step,
                                          input int lo, input int hi);
        int p;
        p = int'(pos);
        if (go_left && !go_right)
            p = p - step;
        else if (go_right && !go_left)
            p = p + step;
        if (p < lo)
            p = lo;
        if (p > hi)
            p = hi;
        return 10'(p);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// rtl/frame_counter.sv - loadable down-counter that decrements once per frame tick and stops at zero
module frame_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load)
            value_d = load_value;
        else if (tick && value_q != '0)
            value_d = value_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/fighter_action_fsm.sv
// rtl/fighter_action_fsm.sv - per-player fighter state machine advanced on the frame tick
// Optional airborne attack window enabled by defining FIGHTER_AIR_ATTACK_EN.
module fighter_action_fsm
    import fighter_pkg::*;
#(
    parameter int X_MIN              = DEF_X_MIN,
    parameter int X_MAX              = DEF_X_MAX,
    parameter int X_INIT             = DEF_X_INIT,
    parameter int WALK_STEP          = DEF_WALK_STEP,
    parameter int JUMP_FRAMES        = DEF_JUMP_FRAMES,
    parameter int JUMP_STEP          = DEF_JUMP_STEP,
    parameter int ATK_ACTIVE_FRAMES  = DEF_ATK_ACTIVE_FRAMES,
    parameter int ATK_RECOVER_FRAMES = DEF_ATK_RECOVER_FRAMES,
    parameter int PARRY_FRAMES       = DEF_PARRY_FRAMES,
    parameter int HITSTUN_FRAMES     = DEF_HITSTUN_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       attack,
    input  logic       pery,
    input  logic       hit_in,
    output logic [2:0] state,
    output logic [9:0] pos_x,
    output logic [7:0] y_off,
    output logic       attack_active,
    output logic       parry_active,
    output logic       parry_success
);

    localparam logic [7:0] JSTEP = 8'(JUMP_STEP);

    fighter_state_e state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [7:0] y_off_q, y_off_d;
    logic attack_prev_q, attack_prev_d, pery_prev_q, pery_prev_d;
    logic attack_active_q, attack_active_d;
    logic parry_active_q, parry_active_d;
    logic parry_success_q, parry_success_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val, cnt_value;
    logic             cnt_zero;
    logic             frame_tick, cnt_last, move_en;
    logic             attack_press, pery_press, walk_in;
    logic             air_active_d;

    // A hit on the same clk as a tick consumes that tick.
    assign frame_tick   = tick & ~hit_in;
    assign cnt_last     = frame_tick & (cnt_value == CNT_W'(1));
    assign attack_press = attack & ~attack_prev_q;
    assign pery_press   = pery & ~pery_prev_q;
    assign walk_in      = left ^ right;

    frame_counter #(.W(CNT_W)) u_main_cnt (
        .clk       (clk),
        .rst       (reset),
        .load      (cnt_load),
        .load_value(cnt_load_val),
        .tick      (frame_tick),
        .value     (cnt_value),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_d         = state_q;
        pos_x_d         = pos_x_q;
        y_off_d         = y_off_q;
        attack_prev_d   = attack_prev_q;
        pery_prev_d     = pery_prev_q;
        cnt_load        = 1'b0;
        cnt_load_val    = '0;
        move_en         = 1'b0;
        parry_success_d = hit_in && (state_q == ST_PARRY);

        if (hit_in) begin
            if (state_q != ST_PARRY) begin
                state_d      = ST_HITSTUN;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(HITSTUN_FRAMES);
                y_off_d      = '0;
            end
        end else if (tick) begin
            attack_prev_d = attack;
            pery_prev_d   = pery;
            case (state_q)
                ST_IDLE, ST_WALK, ST_CROUCH: begin
                    cnt_load = 1'b1;
                    if (pery_press) begin
                        state_d      = ST_PARRY;
                        cnt_load_val = CNT_W'(PARRY_FRAMES);
                    end else if (attack_press) begin
                        state_d      = ST_ATTACK;
                        cnt_load_val = CNT_W'(ATK_ACTIVE_FRAMES);
                    end else if (up) begin
                        state_d      = ST_JUMP;
                        cnt_load_val = CNT_W'(JUMP_FRAMES);
                    end else if (down) begin
                        state_d = ST_CROUCH;
                    end else if (walk_in) begin
                        state_d = ST_WALK;
                        move_en = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_JUMP: begin
                    move_en = 1'b1;
                    if (int'(cnt_value) > JUMP_FRAMES / 2)
                        y_off_d = y_off_q + JSTEP;
                    else
                        y_off_d = y_off_q - JSTEP;
                    if (cnt_last || cnt_zero) begin
                        state_d = ST_IDLE;
                        y_off_d = '0;
                    end
                end
                ST_ATTACK: begin
                    if (cnt_last || cnt_zero) begin
                        state_d      = ST_RECOVER;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(ATK_RECOVER_FRAMES);
                    end
                end
                default: begin
                    // RECOVER, PARRY and HITSTUN all simply time out to IDLE.
                    if (cnt_last || cnt_zero)
                        state_d = ST_IDLE;
                end
            endcase
            if (move_en)
                pos_x_d = step_x(pos_x_q, left, right, WALK_STEP, X_MIN, X_MAX);
        end

        parry_active_d  = (state_d == ST_PARRY);
        attack_active_d = (state_d == ST_ATTACK) || (air_active_d && state_d == ST_JUMP);
    end

`ifdef FIGHTER_AIR_ATTACK_EN
    logic             air_load, air_zero, air_active_q;
    logic [CNT_W-1:0] air_load_val, air_value;

    frame_counter #(.W(CNT_W)) u_air_cnt (
        .clk       (clk),
        .rst       (reset),
        .load      (air_load),
        .load_value(air_load_val),
        .tick      (frame_tick && state_q == ST_JUMP),
        .value     (air_value),
        .zero      (air_zero)
    );

    always_comb begin
        air_load     = 1'b0;
        air_load_val = '0;
        air_active_d = air_active_q;
        if (hit_in) begin
            if (state_q != ST_PARRY) begin
                air_load     = 1'b1;
                air_active_d = 1'b0;
            end
        end else if (tick && state_q == ST_JUMP) begin
            if (cnt_last) begin
                air_load     = 1'b1;
                air_active_d = 1'b0;
            end else if (attack_press && air_zero) begin
                air_load     = 1'b1;
                air_load_val = CNT_W'(ATK_ACTIVE_FRAMES);
                air_active_d = 1'b1;
            end else if (air_value == CNT_W'(1)) begin
                air_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            air_active_q <= 1'b0;
        else
            air_active_q <= air_active_d;
    end
`else
    assign air_active_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            pos_x_q         <= 10'(X_INIT);
            y_off_q         <= '0;
            attack_prev_q   <= 1'b0;
            pery_prev_q     <= 1'b0;
            attack_active_q <= 1'b0;
            parry_active_q  <= 1'b0;
            parry_success_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pos_x_q         <= pos_x_d;
            y_off_q         <= y_off_d;
            attack_prev_q   <= attack_prev_d;
            pery_prev_q     <= pery_prev_d;
            attack_active_q <= attack_active_d;
            parry_active_q  <= parry_active_d;
            parry_success_q <= parry_success_d;
        end
    end

    assign state         = state_q;
    assign pos_x         = pos_x_q;
    assign y_off         = y_off_q;
    assign attack_active = attack_active_q;
    assign parry_active  = parry_active_q;
    assign parry_success = parry_success_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// tb/tb_fighter_action_fsm.sv - directed and randomized checks of fighter_action_fsm against a frame-level model
module tb_fighter_action_fsm;

    logic       clk = 1'b0;
    logic       reset, tick, left, right, up, down, attack, pery, hit_in;
    logic [2:0] state;
    logic [9:0] pos_x;
    logic [7:0] y_off;
    logic       attack_active, parry_active, parry_success;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fighter_action_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .left         (left),
        .right        (right),
        .up           (up),
        .down         (down),
        .attack       (attack),
        .pery         (pery),
        .hit_in       (hit_in),
        .state        (state),
        .pos_x        (pos_x),
        .y_off        (y_off),
        .attack_active(attack_active),
        .parry_active (parry_active),
        .parry_success(parry_success)
    );

    // Reference: named phase, remaining frames, jump frames elapsed.
    int m_state, m_x, m_y, m_left, m_jt;
    bit m_aprev, m_pprev, m_ps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 64; m_y = 0; m_left = 0; m_jt = 0;
        m_aprev = 0; m_pprev = 0; m_ps = 0;
    endtask

    function automatic int clamp_x(input int v);
        if (v < 0) return 0;
        if (v > 575) return 575;
        return v;
    endfunction

    task automatic model_step();
        bit ap, pp;
        int dx;
        m_ps = hit_in && (m_state == 6);
        if (hit_in) begin
            if (m_state != 6) begin
                m_state = 7; m_left = 20; m_y = 0;
            end
        end else if (tick) begin
            ap = attack && !m_aprev;
            pp = pery && !m_pprev;
            m_aprev = attack;
            m_pprev = pery;
            dx = (right && !left) ? 2 : ((left && !right) ? -2 : 0);
            if (m_state == 0 || m_state == 1 || m_state == 3) begin
                if (pp)            begin m_state = 6; m_left = 8; end
                else if (ap)       begin m_state = 4; m_left = 6; end
                else if (up)       begin m_state = 2; m_jt = 0; end
                else if (down)     m_state = 3;
                else if (dx != 0)  begin m_state = 1; m_x = clamp_x(m_x + dx); end
                else               m_state = 0;
            end else if (m_state == 2) begin
                m_x  = clamp_x(m_x + dx);
                m_jt = m_jt + 1;
                m_y  = 4 * ((m_jt < 32 - m_jt) ? m_jt : 32 - m_jt);
                if (m_jt == 32) m_state = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_state == 4) begin m_state = 5; m_left = 10; end
                    else m_state = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("state", state, m_state);
        check("pos_x", pos_x, m_x);
        check("y_off", y_off, m_y);
        check("attack_active", attack_active, m_state == 4);
        check("parry_active", parry_active, m_state == 6);
        check("parry_success", parry_success, m_ps);
    endtask

    task automatic clk1();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic tick1();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        clk1();
    endtask

    task automatic apply_reset();
        {tick, left, right, up, down, attack, pery, hit_in} = '0;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_state", state, 0);
        check("rst_pos_x", pos_x, 64);
        check("rst_y_off", y_off, 0);
        check("rst_flags", {attack_active, parry_active, parry_success}, 0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n_atk, n_rec;
        {tick, left, right, up, down, attack, pery, hit_in} = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Walk right, then release.
        right = 1'b1;
        repeat (10) tick1();
        check("walk_pos", pos_x, 84);
        check("walk_state", state, 1);
        right = 1'b0;
        tick1();
        check("release_idle", state, 0);

        // Right edge saturation, then both directions held.
        right = 1'b1;
        repeat (245) tick1();
        check("edge_574", pos_x, 574);
        repeat (3) tick1();
        check("edge_sat", pos_x, 575);
        left = 1'b1;
        tick1();
        check("lr_state", state, 0);
        check("lr_pos", pos_x, 575);
        {left, right} = '0;

        // Full jump arc with right held.
        apply_reset();
        up = 1'b1; right = 1'b1;
        tick1();
        up = 1'b0;
        check("jump_entry", state, 2);
        repeat (16) tick1();
        check("jump_peak", y_off, 64);
        repeat (15) tick1();
        check("jump_last", y_off, 4);
        tick1();
        check("jump_land_y", y_off, 0);
        check("jump_land_state", state, 0);
        check("jump_pos", pos_x, 128);
        right = 1'b0;

        // Held attack: one active window, one recovery, no retrigger.
        apply_reset();
        attack = 1'b1;
        n_atk = 0; n_rec = 0;
        repeat (30) begin
            tick1();
            if (attack_active) n_atk++;
            if (state == 3'd5) n_rec++;
        end
        check("atk_frames", n_atk, 6);
        check("rec_frames", n_rec, 10);
        check("atk_end_state", state, 0);
        attack = 1'b0;

        // Parry, hit on the third parry frame.
        apply_reset();
        pery = 1'b1;
        tick1();
        pery = 1'b0;
        check("parry_entry", state, 6);
        repeat (2) tick1();
        hit_in = 1'b1;
        clk1();
        hit_in = 1'b0;
        check("parry_pulse", parry_success, 1);
        check("parry_hold", state, 6);
        clk1();
        check("parry_pulse_end", parry_success, 0);
        repeat (5) tick1();
        check("parry_still", state, 6);
        tick1();
        check("parry_done", state, 0);

        // Hit mid-jump on a tick, then a re-hit during stun.
        apply_reset();
        up = 1'b1;
        tick1();
        up = 1'b0;
        repeat (5) tick1();
        check("rise_y", y_off, 20);
        tick = 1'b1; hit_in = 1'b1;
        clk1();
        tick = 1'b0; hit_in = 1'b0;
        check("stun_state", state, 7);
        check("stun_y", y_off, 0);
        clk1();
        repeat (14) tick1();
        hit_in = 1'b1;
        clk1();
        hit_in = 1'b0;
        repeat (19) tick1();
        check("restun_hold", state, 7);
        tick1();
        check("restun_done", state, 0);

        // Randomized traffic with occasional asynchronous resets.
        apply_reset();
        for (int i = 0; i < 5000; i++) begin
            tick   = ($urandom_range(0, 3) == 0);
            hit_in = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 7) == 0) left   = ~left;
            if ($urandom_range(0, 7) == 0) right  = ~right;
            if ($urandom_range(0, 11) == 0) up    = ~up;
            if ($urandom_range(0, 9) == 0) down   = ~down;
            if ($urandom_range(0, 9) == 0) attack = ~attack;
            if ($urandom_range(0, 9) == 0) pery   = ~pery;
            clk1();
            if ($urandom_range(0, 700) == 0)
                apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
